rf_writeback_queue: RTL and testbench

- Write-side initiator for the 32x32 register file.
- Accepts writeback requests from execution/memory units over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per cycle onto the register file's write port (write_reg/write_value).
- Provides two combinational forwarding lookups so readers see pending (not yet written) values.

---
 rtl/rf_wb_pkg.sv | 16 +
 rtl/rf_wb_forward_mux.sv | 29 ++
 rtl/rf_writeback_queue.sv | 132 +++++++++++++
 tb/tb_rf_writeback_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
package rf_wb_pkg;

   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned DATA_WIDTH = 32;

   // Writes to register 0 are architecturally discarded.
   localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

   // One pending register write ("reg" is a keyword, hence reg_idx).
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] reg_idx;
      logic [DATA_WIDTH-1:0] value;
   } wb_entry_t;

endpackage

// File: rtl/rf_wb_forward_mux.sv
// Youngest-match search over pending writes for one forwarding port.
// Candidates are ordered oldest (index 0) to youngest (index NUM_CAND-1).
module rf_wb_forward_mux
   import rf_wb_pkg::*;
#(
   parameter int unsigned NUM_CAND = 5
) (
   input  logic [NUM_CAND-1:0]   cand_valid,
   input  wb_entry_t             cand [NUM_CAND],
   input  logic [ADDR_WIDTH-1:0] lookup_reg,
   output logic                  lookup_hit,
   output logic [DATA_WIDTH-1:0] lookup_value
);

   // Scan oldest to youngest so the last (youngest) match wins.
   always_comb begin
      lookup_hit   = 1'b0;
      lookup_value = '0;
      if (lookup_reg != ZERO_REG) begin
         for (int i = 0; i < int'(NUM_CAND); i++) begin
            if (cand_valid[i] && (cand[i].reg_idx == lookup_reg)) begin
               lookup_hit   = 1'b1;
               lookup_value = cand[i].value;
            end
         end
      end
   end

endmodule

// File: rtl/rf_writeback_queue.sv
// Writeback queue in front of the 32x32 register file write port.
// Requests are buffered in an in-order FIFO and drained one per cycle into
// registered rf_write_* outputs; two ports forward not-yet-written values.
// The entry type is fixed to the package widths; ADDR_WIDTH/DATA_WIDTH must
// match rf_wb_pkg.
module rf_writeback_queue #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [ADDR_WIDTH-1:0]      wb_reg,
   input  logic [DATA_WIDTH-1:0]      wb_value,
   output logic [ADDR_WIDTH-1:0]      rf_write_reg,
   output logic [DATA_WIDTH-1:0]      rf_write_value,
   input  logic [ADDR_WIDTH-1:0]      lookup_reg1,
   output logic                       lookup_hit1,
   output logic [DATA_WIDTH-1:0]      lookup_value1,
   input  logic [ADDR_WIDTH-1:0]      lookup_reg2,
   output logic                       lookup_hit2,
   output logic [DATA_WIDTH-1:0]      lookup_value2,
   output logic [$clog2(DEPTH):0]     pending_count
);

   import rf_wb_pkg::wb_entry_t;
   import rf_wb_pkg::ZERO_REG;

   localparam int unsigned PW       = $clog2(DEPTH);
   localparam int unsigned CW       = $clog2(DEPTH) + 1;
   localparam int unsigned NUM_CAND = DEPTH + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   wb_entry_t         fifo_q [DEPTH];
   logic [PW-1:0]     head_q;
   logic [PW-1:0]     tail_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   wb_entry_t         out_q;

   logic              fire;
   logic              push;
   logic              pop;

   wb_entry_t             cand [NUM_CAND];
   logic [NUM_CAND-1:0]   cand_valid;

   // Ready depends on state only; a pop on the same edge does not free a slot.
   assign wb_ready = !rst && (count_q < FULL_CNT);
   assign fire     = wb_valid && wb_ready;
   // Register-0 writes complete the handshake but are never stored.
   assign push     = fire && (wb_reg != ZERO_REG);
   assign pop      = (count_q != '0);

   // Occupancy next state: push and pop together leave it unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Entry storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[tail_q] <= '{reg_idx: wb_reg, value: wb_value};
      end
   end

   // Pointers, occupancy and the registered write-port stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         out_q   <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            tail_q <= tail_q + 1'b1;
         end
         if (pop) begin
            out_q  <= fifo_q[head_q];
            head_q <= head_q + 1'b1;
         end else begin
            out_q  <= '0;
         end
      end
   end

   assign rf_write_reg   = out_q.reg_idx;
   assign rf_write_value = out_q.value;
   assign pending_count  = count_q;

   // Candidate list oldest-first: output stage, then FIFO from head onward.
   always_comb begin
      logic [PW-1:0] idx;
      cand_valid    = '0;
      cand[0]       = out_q;
      cand_valid[0] = (out_q.reg_idx != ZERO_REG);
      for (int k = 0; k < int'(DEPTH); k++) begin
         idx               = head_q + PW'(k);
         cand[k+1]         = fifo_q[idx];
         cand_valid[k+1]   = (CW'(k) < count_q);
      end
   end

   rf_wb_forward_mux #(
      .NUM_CAND (NUM_CAND)
   ) u_fwd1 (
      .cand_valid   (cand_valid),
      .cand         (cand),
      .lookup_reg   (lookup_reg1),
      .lookup_hit   (lookup_hit1),
      .lookup_value (lookup_value1)
   );

   rf_wb_forward_mux #(
      .NUM_CAND (NUM_CAND)
   ) u_fwd2 (
      .cand_valid   (cand_valid),
      .cand         (cand),
      .lookup_reg   (lookup_reg2),
      .lookup_hit   (lookup_hit2),
      .lookup_value (lookup_value2)
   );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue with a small queue model.
module tb_rf_writeback_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_reg;
   logic [31:0] wb_value;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_value;
   logic [4:0]  lookup_reg1;
   logic        lookup_hit1;
   logic [31:0] lookup_value1;
   logic [4:0]  lookup_reg2;
   logic        lookup_hit2;
   logic [31:0] lookup_value2;
   logic [2:0]  pending_count;

   rf_writeback_queue #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_reg         (wb_reg),
      .wb_value       (wb_value),
      .rf_write_reg   (rf_write_reg),
      .rf_write_value (rf_write_value),
      .lookup_reg1    (lookup_reg1),
      .lookup_hit1    (lookup_hit1),
      .lookup_value1  (lookup_value1),
      .lookup_reg2    (lookup_reg2),
      .lookup_hit2    (lookup_hit2),
      .lookup_value2  (lookup_value2),
      .pending_count  (pending_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] v;
   } ent_t;

   ent_t q[$];
   ent_t out_m;
   ent_t emitted[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   n_acc = 0;
   int   max_pend = 0;
   bit   last_fire;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void fwd(input logic [4:0] r, output logic hit, output logic [31:0] v);
      hit = 1'b0;
      v   = '0;
      if (r != 0) begin
         if (out_m.r == r) begin
            hit = 1'b1;
            v   = out_m.v;
         end
         foreach (q[i]) begin
            if (q[i].r == r) begin
               hit = 1'b1;
               v   = q[i].v;
            end
         end
      end
   endfunction

   task automatic check_model();
      logic        h;
      logic [31:0] v;
      check("rf_write_reg", {27'd0, rf_write_reg}, {27'd0, out_m.r});
      check("rf_write_value", rf_write_value, out_m.v);
      check("pending_count", {29'd0, pending_count}, q.size());
      check("wb_ready", {31'd0, wb_ready}, {31'd0, (!rst && q.size() < DEPTH)});
      fwd(lookup_reg1, h, v);
      check("lookup_hit1", {31'd0, lookup_hit1}, {31'd0, h});
      check("lookup_value1", lookup_value1, v);
      fwd(lookup_reg2, h, v);
      check("lookup_hit2", {31'd0, lookup_hit2}, {31'd0, h});
      check("lookup_value2", lookup_value2, v);
   endtask

   // Advance one clock edge and update the model from the inputs seen there.
   task automatic cycle();
      bit f;
      f = wb_valid && !rst && (q.size() < DEPTH);
      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         out_m = '{5'd0, 32'd0};
      end else begin
         if (q.size() > 0) out_m = q.pop_front();
         else out_m = '{5'd0, 32'd0};
         if (f && wb_reg != 0) q.push_back('{wb_reg, wb_value});
      end
      if (out_m.r != 0) emitted.push_back(out_m);
      if (f) n_acc++;
      last_fire = f;
      if (int'(pending_count) > max_pend) max_pend = int'(pending_count);
      check_model();
   endtask

   initial begin
      int i;
      int guard;
      int bad;
      rst = 1'b1;
      wb_valid = 1'b0;
      wb_reg = '0;
      wb_value = '0;
      lookup_reg1 = '0;
      lookup_reg2 = '0;

      // Reset
      cycle();
      check("ready_in_rst", {31'd0, wb_ready}, 32'd0);
      check("reset_write_reg", {27'd0, rf_write_reg}, 32'd0);
      cycle();
      check("reset_pending", {29'd0, pending_count}, 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, wb_ready}, 32'd1);

      // Single write: appears after the second edge, for one cycle
      emitted.delete();
      wb_valid = 1'b1; wb_reg = 5'd5; wb_value = 32'hDEADBEEF; lookup_reg1 = 5'd5;
      cycle();
      wb_valid = 1'b0; wb_reg = '0; wb_value = '0;
      #1;
      check("single_no_passthru", {27'd0, rf_write_reg}, 32'd0);
      check("single_pending", {29'd0, pending_count}, 32'd1);
      check("single_fwd_hit", {31'd0, lookup_hit1}, 32'd1);
      check("single_fwd_value", lookup_value1, 32'hDEADBEEF);
      cycle();
      check("single_reg", {27'd0, rf_write_reg}, 32'd5);
      check("single_value", rf_write_value, 32'hDEADBEEF);
      cycle();
      check("single_after_reg", {27'd0, rf_write_reg}, 32'd0);
      check("single_after_value", rf_write_value, 32'd0);
      check("single_count", emitted.size(), 32'd1);

      // Streaming regs 1..6
      emitted.delete(); max_pend = 0; lookup_reg1 = 5'd3; lookup_reg2 = 5'd6;
      i = 0; guard = 0;
      while (i < 6 && guard < 60) begin
         wb_valid = 1'b1; wb_reg = 5'(i + 1); wb_value = 32'(100 + i);
         cycle();
         if (last_fire) i++;
         guard++;
      end
      wb_valid = 1'b0;
      repeat (3) cycle();
      check("stream_accepted", i, 32'd6);
      check("stream_pending_le4", {31'd0, (max_pend <= 4)}, 32'd1);
      check("stream_count", emitted.size(), 32'd6);
      for (int k = 0; k < 6 && k < emitted.size(); k++) begin
         check("stream_reg", {27'd0, emitted[k].r}, 32'(k + 1));
         check("stream_value", emitted[k].v, 32'(100 + k));
      end

      // Register 0 is accepted but dropped
      emitted.delete(); n_acc = 0; max_pend = 0; lookup_reg1 = 5'd0; lookup_reg2 = 5'd3;
      wb_valid = 1'b1; wb_reg = 5'd0; wb_value = 32'd7;
      cycle();
      check("r0_pending", {29'd0, pending_count}, 32'd0);
      wb_reg = 5'd3; wb_value = 32'd9;
      cycle();
      wb_valid = 1'b0;
      check("r3_pending", {29'd0, pending_count}, 32'd1);
      cycle();
      check("r3_reg", {27'd0, rf_write_reg}, 32'd3);
      check("r3_value", rf_write_value, 32'd9);
      cycle();
      check("r0_handshakes", n_acc, 32'd2);
      check("r0_peak", max_pend, 32'd1);
      check("r0_emitted", emitted.size(), 32'd1);

      // Forwarding priority: FIFO newest first, output stage last
      lookup_reg1 = 5'd8; lookup_reg2 = 5'd0;
      wb_valid = 1'b1; wb_reg = 5'd8; wb_value = 32'd1;
      cycle();
      check("fwd_fifo_only", lookup_value1, 32'd1);
      wb_value = 32'd2;
      cycle();
      check("fwd_out_reg", {27'd0, rf_write_reg}, 32'd8);
      check("fwd_out_value", rf_write_value, 32'd1);
      check("fwd_hit_2", {31'd0, lookup_hit1}, 32'd1);
      check("fwd_value_2", lookup_value1, 32'd2);
      check("fwd_r0_hit", {31'd0, lookup_hit2}, 32'd0);
      check("fwd_r0_value", lookup_value2, 32'd0);
      wb_value = 32'd3;
      cycle();
      check("fwd_value_3", lookup_value1, 32'd3);
      wb_valid = 1'b0;
      cycle();
      check("fwd_out_only", lookup_value1, 32'd3);
      lookup_reg1 = 5'd9; lookup_reg2 = 5'd8;
      #1;
      check("fwd_miss_hit", {31'd0, lookup_hit1}, 32'd0);
      check("fwd_miss_value", lookup_value1, 32'd0);
      check("fwd_port2_hit", {31'd0, lookup_hit2}, 32'd1);
      check("fwd_port2_value", lookup_value2, 32'd3);
      cycle();
      check("fwd_drained", {31'd0, lookup_hit2}, 32'd0);

      // Reset mid-drain discards queued writes
      emitted.delete(); lookup_reg1 = 5'd4; lookup_reg2 = 5'd6;
      wb_valid = 1'b1; wb_reg = 5'd4; wb_value = 32'd40;
      cycle();
      wb_reg = 5'd6; wb_value = 32'd60;
      cycle();
      check("mid_out_reg", {27'd0, rf_write_reg}, 32'd4);
      wb_reg = 5'd7; wb_value = 32'd70;
      rst = 1'b1;
      #1;
      check("mid_ready_rst", {31'd0, wb_ready}, 32'd0);
      cycle();
      rst = 1'b0; wb_valid = 1'b0;
      #1;
      check("mid_reg", {27'd0, rf_write_reg}, 32'd0);
      check("mid_pending", {29'd0, pending_count}, 32'd0);
      check("mid_hit1", {31'd0, lookup_hit1}, 32'd0);
      check("mid_hit2", {31'd0, lookup_hit2}, 32'd0);
      repeat (4) cycle();
      bad = 0;
      foreach (emitted[k]) if (emitted[k].r == 5'd6 || emitted[k].r == 5'd7) bad++;
      check("mid_discarded", bad, 32'd0);

      // Wrap-around with random valid gaps
      emitted.delete(); lookup_reg1 = 5'd2; lookup_reg2 = 5'd10;
      i = 0; guard = 0;
      while (i < 10 && guard < 300) begin
         wb_valid = 1'($urandom_range(0, 1));
         wb_reg = 5'(i + 1); wb_value = 32'(i * 3);
         cycle();
         if (last_fire) i++;
         guard++;
      end
      wb_valid = 1'b0;
      repeat (4) cycle();
      check("wrap_accepted", i, 32'd10);
      check("wrap_count", emitted.size(), 32'd10);
      for (int k = 0; k < 10 && k < emitted.size(); k++) begin
         check("wrap_reg", {27'd0, emitted[k].r}, 32'(k + 1));
         check("wrap_value", emitted[k].v, 32'(k * 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
